// File: rtl/seq_multiplier.sv
// Sequential 32x32 shift-add multiplier covering MUL / MULH / MULHSU / MULHU.
// Operands are reduced to magnitudes on acceptance, multiplied over 32
// iterations with a single ripple adder, and the sign is re-applied once
// the full 64-bit product is available.
module seq_multiplier #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_rs1,
  input  logic [DATA_W-1:0] i_rs2,
  input  logic              i_flush,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              state_q,  state_d;
  logic [1:0]          op_q,     op_d;
  logic [DATA_W-1:0]   mcand_q,  mcand_d;
  logic                sign_q,   sign_d;
  logic [DATA_W-1:0]   high_q,   high_d;
  logic [DATA_W-1:0]   low_q,    low_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic                valid_q,  valid_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic                rs1_signed;
  logic                rs2_signed;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;

  // Magnitude of an operand; 0x80000000 maps onto itself, read as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x,
                                                  input logic              is_signed);
    magnitude = (is_signed && x[DATA_W-1]) ? (~x + 1'b1) : x;
  endfunction

  // Two's-complement negation of the full product when the sign is set.
  function automatic logic [2*DATA_W-1:0] apply_sign(input logic [2*DATA_W-1:0] p,
                                                     input logic                neg);
    apply_sign = neg ? (~p + 1'b1) : p;
  endfunction

  assign rs1_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU);
  assign rs2_signed = (i_op == OP_MULH);

  // Shared ripple adder: conditionally add the multiplicand magnitude to the high half.
  assign sum  = {1'b0, high_q} + {1'b0, (low_q[0] ? mcand_q : '0)};
  assign prod = apply_sign({high_q, low_q}, sign_q);

  // Next-state and datapath update for the IDLE -> CALC -> FIN sequence.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    sign_d   = sign_q;
    high_d   = high_q;
    low_d    = low_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start && !i_flush) begin
          op_d    = i_op;
          mcand_d = magnitude(i_rs1, rs1_signed);
          sign_d  = (rs1_signed & i_rs1[DATA_W-1]) ^ (rs2_signed & i_rs2[DATA_W-1]);
          high_d  = '0;
          low_d   = magnitude(i_rs2, rs2_signed);
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        high_d = sum[DATA_W:1];
        low_d  = {sum[0], low_q[DATA_W-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        result_d = (op_q == OP_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything: no strobe, previous result kept.
    if (i_flush) begin
      state_d  = S_IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      sign_q   <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      sign_q   <= sign_d;
      high_q   <= high_d;
      low_q    <= low_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule
